// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Shared types and default sizes for the RAM write-port arbiter slice.
// Contents:
//   state_t      CLEAR while the RAM is being zeroed, RUN while writers are served
//   CNT_W        width of each per-writer grant counter
//   DEF_*        default writer count, RAM geometry used by ram_write_arbiter
package ram_arb_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam int CNT_W       = 16;
   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_ADDR_W  = 8;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_DEPTH   = 256;

endpackage

// File: rtl/ram_write_arbiter_rr_arbiter.sv
// rr_arbiter
// Round-robin pick among NUM_REQ requesters. The search starts at the
// priority pointer and wraps; the pointer moves just past the winner on
// every accepted grant, so a continuously requesting input waits for at
// most NUM_REQ-1 other grants.
// Ports:
//   i_clk      clock, rising edge
//   i_rst      asynchronous active-high reset (pointer back to 0)
//   i_valid    request vector
//   i_advance  the current winner was accepted this cycle
//   i_restart  return the pointer to 0 (synchronous)
//   o_grant    one-hot winner, zero when nobody requests
//   o_winner   index of the winner (0 when nobody requests)
//   o_any      at least one request is present
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [NUM_REQ-1:0]         i_valid,
   input  logic                       i_advance,
   input  logic                       i_restart,
   output logic [NUM_REQ-1:0]         o_grant,
   output logic [$clog2(NUM_REQ)-1:0] o_winner,
   output logic                       o_any
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0] r_rrPtr;
   logic [IDX_W-1:0] w_scan;
   logic             w_found;

   // Walk the requesters starting at the pointer; the first one found wins.
   // The modulo keeps the scan inside 0..NUM_REQ-1 for non power-of-two counts.
   always_comb begin
      o_grant  = '0;
      o_winner = '0;
      w_found  = 1'b0;
      w_scan   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_scan = IDX_W'((int'(r_rrPtr) + k) % NUM_REQ);
         if (!w_found && i_valid[w_scan]) begin
            w_found  = 1'b1;
            o_winner = w_scan;
         end
      end
      if (w_found) begin
         o_grant[o_winner] = 1'b1;
      end
      o_any = w_found;
   end

   // The pointer only moves on an accepted grant so an unaccepted cycle
   // leaves priority where it was.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rrPtr <= '0;
      end else if (i_restart) begin
         r_rrPtr <= '0;
      end else if (i_advance) begin
         r_rrPtr <= (o_winner == IDX_W'(NUM_REQ - 1)) ? '0 : o_winner + 1'b1;
      end
   end

endmodule

// File: rtl/ram_write_arbiter.sv
// ram_write_arbiter
// Owns the single write port of the shared multi-read RAM. After reset, or
// when clr_start is pulsed while running, every word is written with zero
// (the RAM itself has no reset). Once clearing is finished, NUM_REQ writers
// share the port round-robin. Every RAM write leaves through a register, so
// there is no combinational path from writer address/data to the RAM.
// Optional feature macro: RAM_ARB_STATS_EN builds saturating per-writer
// grant counters; without it grant_count is tied to zero.
// Ports:
//   signal_C     clock, rising edge
//   signal_R     asynchronous active-high reset
//   req_valid    per-writer write request
//   req_ready    one-hot grant (zero outside RUN and on a clr_start cycle)
//   req_addr     per-writer address, writer i at [i*ADDR_W +: ADDR_W]
//   req_data     per-writer data, writer i at [i*DATA_W +: DATA_W]
//   clr_start    re-zero the whole RAM (ignored while already clearing)
//   init_done    high while in RUN
//   ram_we       RAM write enable
//   ram_addr     RAM write address
//   ram_data     RAM write data
//   grant_count  per-writer grant counters, writer i at [i*16 +: 16]
module ram_write_arbiter
   import ram_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int DEPTH   = DEF_DEPTH
) (
   input  logic                      signal_C,
   input  logic                      signal_R,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic                      clr_start,
   output logic                      init_done,
   output logic                      ram_we,
   output logic [ADDR_W-1:0]         ram_addr,
   output logic [DATA_W-1:0]         ram_data,
   output logic [NUM_REQ*CNT_W-1:0]  grant_count
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [ADDR_W:0] CLR_END = (ADDR_W + 1)'(DEPTH);

   state_t              r_state;
   state_t              w_nextState;
   logic [ADDR_W:0]     r_clrCnt;
   logic                w_clrIssue;
   logic                w_handshake;
   logic                w_enterClear;
   logic [NUM_REQ-1:0]  w_grant;
   logic [IDX_W-1:0]    w_winner;
   logic                w_any;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rrArbiter (
      .i_clk     (signal_C),
      .i_rst     (signal_R),
      .i_valid   (req_valid),
      .i_advance (w_handshake),
      .i_restart (w_enterClear),
      .o_grant   (w_grant),
      .o_winner  (w_winner),
      .o_any     (w_any)
   );

   // State register for the CLEAR/RUN controller.
   always_ff @(posedge signal_C or posedge signal_R) begin
      if (signal_R) begin
         r_state <= CLEAR;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state and the grant gating. The clear counter runs one step past
   // the last address so the final zero write is on the bus before RUN
   // begins. A clr_start cycle withholds every grant so no writer believes
   // it was accepted while the RAM is about to be wiped.
   always_comb begin
      w_nextState  = r_state;
      w_clrIssue   = 1'b0;
      w_handshake  = 1'b0;
      w_enterClear = 1'b0;
      req_ready    = '0;
      case (r_state)
         CLEAR: begin
            if (r_clrCnt == CLR_END) begin
               w_nextState = RUN;
            end else begin
               w_clrIssue = 1'b1;
            end
         end
         RUN: begin
            if (clr_start) begin
               w_nextState  = CLEAR;
               w_enterClear = 1'b1;
            end else begin
               req_ready   = w_grant;
               w_handshake = w_any;
            end
         end
         default: begin
            w_nextState = CLEAR;
         end
      endcase
   end

   assign init_done = (r_state == RUN);

   // Clear address counter; restarts from zero whenever clearing is re-entered.
   always_ff @(posedge signal_C or posedge signal_R) begin
      if (signal_R) begin
         r_clrCnt <= '0;
      end else if (w_enterClear) begin
         r_clrCnt <= '0;
      end else if (w_clrIssue) begin
         r_clrCnt <= r_clrCnt + 1'b1;
      end
   end

   // Registered RAM write stage. Address and data hold when nothing is
   // written so the RAM inputs do not toggle needlessly.
   always_ff @(posedge signal_C or posedge signal_R) begin
      if (signal_R) begin
         ram_we   <= 1'b0;
         ram_addr <= '0;
         ram_data <= '0;
      end else if (w_clrIssue) begin
         ram_we   <= 1'b1;
         ram_addr <= r_clrCnt[ADDR_W-1:0];
         ram_data <= '0;
      end else if (w_handshake) begin
         ram_we   <= 1'b1;
         ram_addr <= req_addr[int'(w_winner)*ADDR_W +: ADDR_W];
         ram_data <= req_data[int'(w_winner)*DATA_W +: DATA_W];
      end else begin
         ram_we   <= 1'b0;
      end
   end

`ifdef RAM_ARB_STATS_EN
   logic [CNT_W-1:0] r_grantCnt [NUM_REQ];

   // Per-writer grant counters, saturating so a busy writer never wraps to a
   // misleadingly small count. Wiped together with the RAM.
   always_ff @(posedge signal_C or posedge signal_R) begin
      if (signal_R) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            r_grantCnt[i] <= '0;
         end
      end else if (w_enterClear) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            r_grantCnt[i] <= '0;
         end
      end else if (w_handshake && (r_grantCnt[w_winner] != {CNT_W{1'b1}})) begin
         r_grantCnt[w_winner] <= r_grantCnt[w_winner] + 1'b1;
      end
   end

   // Flatten the counters onto the output bus.
   always_comb begin
      grant_count = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_count[i*CNT_W +: CNT_W] = r_grantCnt[i];
      end
   end
`else
   assign grant_count = '0;
`endif

endmodule

// File: tb/tb_ram_write_arbiter.sv
// tb_ram_write_arbiter
// Self-checking bench for ram_write_arbiter. A behavioural model tracks the
// run/clear mode, clear progress, round-robin priority and expected write
// port contents; a shadow RAM records every write the DUT issues.
module tb_ram_write_arbiter;

   localparam int NREQ  = 4;
   localparam int AW    = 8;
   localparam int DW    = 32;
   localparam int DEPTH = 256;

   logic                 signal_C = 1'b0;
   logic                 signal_R = 1'b1;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*AW-1:0]   req_addr = '0;
   logic [NREQ*DW-1:0]   req_data = '0;
   logic                 clr_start = 1'b0;
   logic                 init_done;
   logic                 ram_we;
   logic [AW-1:0]        ram_addr;
   logic [DW-1:0]        ram_data;
   logic [NREQ*16-1:0]   grant_count;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] shadowRam [DEPTH];

   bit            mRun;
   int            mClr;
   int            mPtr;
   bit            mWe;
   logic [AW-1:0] mAddr;
   logic [DW-1:0] mData;
   int            mCnt [NREQ];

   ram_write_arbiter #(
      .NUM_REQ (NREQ),
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .DEPTH   (DEPTH)
   ) dut (
      .signal_C    (signal_C),
      .signal_R    (signal_R),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .clr_start   (clr_start),
      .init_done   (init_done),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_data    (ram_data),
      .grant_count (grant_count)
   );

   always #5 signal_C = ~signal_C;

   // Shadow RAM: each registered write is visible for one full cycle.
   always @(negedge signal_C) begin
      if (!signal_R && ram_we === 1'b1) begin
         shadowRam[ram_addr] = ram_data;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int pickWinner(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] expectedReady();
      logic [NREQ-1:0] r;
      int w;
      r = '0;
      if (mRun && !clr_start) begin
         w = pickWinner(req_valid, mPtr);
         if (w >= 0) r[w] = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [NREQ*16-1:0] expectedCounts();
      logic [NREQ*16-1:0] c;
      c = '0;
`ifdef RAM_ARB_STATS_EN
      for (int i = 0; i < NREQ; i++) c[i*16 +: 16] = 16'(mCnt[i]);
`endif
      return c;
   endfunction

   task automatic modelReset();
      mRun = 0; mClr = 0; mPtr = 0; mWe = 0; mAddr = '0; mData = '0;
      for (int i = 0; i < NREQ; i++) mCnt[i] = 0;
   endtask

   task automatic modelEdge();
      int w;
      if (!mRun) begin
         if (mClr < DEPTH) begin
            mWe = 1; mAddr = AW'(mClr); mData = '0; mClr++;
         end else begin
            mRun = 1; mWe = 0;
         end
      end else if (clr_start) begin
         mRun = 0; mClr = 0; mWe = 0; mPtr = 0;
         for (int i = 0; i < NREQ; i++) mCnt[i] = 0;
      end else begin
         w = pickWinner(req_valid, mPtr);
         if (w >= 0) begin
            mWe = 1;
            mAddr = req_addr[w*AW +: AW];
            mData = req_data[w*DW +: DW];
            mPtr = (w + 1) % NREQ;
            if (mCnt[w] < 65535) mCnt[w]++;
         end else begin
            mWe = 0;
         end
      end
   endtask

   task automatic clockEdge();
      @(posedge signal_C);
      if (!signal_R) modelEdge();
      #1;
   endtask

   task automatic randomizeData();
      for (int i = 0; i < NREQ; i++) begin
         req_addr[i*AW +: AW] = AW'($urandom);
         req_data[i*DW +: DW] = $urandom;
      end
   endtask

   task automatic test_reset();
      signal_R = 1'b1; clr_start = 1'b0; req_valid = '1;
      randomizeData();
      modelReset();
      repeat (3) @(posedge signal_C);
      @(negedge signal_C);
      checks++;
      if ({ram_we, ram_addr, ram_data} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_ram: got we=%b addr=%h data=%h, expected all zero", ram_we, ram_addr, ram_data);
      end
      checks++;
      if ({init_done, req_ready} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got init_done=%b ready=%b, expected 0/0000", init_done, req_ready);
      end
      checks++;
      if (grant_count !== '0) begin
         errors++;
         $display("[TB] FAIL reset_stats: got %h expected 0", grant_count);
      end
      signal_R = 1'b0;
   endtask

   task automatic test_clear();
      int weCycles;
      int firstRunEdge;
      int nonZero;
      weCycles = 0; firstRunEdge = -1; nonZero = 0;
      for (int e = 1; e <= DEPTH + 20 && firstRunEdge < 0; e++) begin
         req_valid = NREQ'($urandom);
         clr_start = 1'($urandom);
         randomizeData();
         #1;
         checks++;
         if (req_ready !== expectedReady()) begin
            errors++;
            $display("[TB] FAIL clear_ready: got %b expected %b", req_ready, expectedReady());
         end
         clockEdge();
         @(negedge signal_C);
         checks++;
         if ({init_done, ram_we, ram_addr, ram_data} !== {mRun, mWe, mAddr, mData}) begin
            errors++;
            $display("[TB] FAIL clear_write: got done=%b we=%b addr=%h data=%h expected done=%b we=%b addr=%h data=%h",
                     init_done, ram_we, ram_addr, ram_data, mRun, mWe, mAddr, mData);
         end
         if (ram_we === 1'b1) weCycles++;
         if (init_done === 1'b1) firstRunEdge = e;
      end
      clr_start = 1'b0; req_valid = '0;
      checks++;
      if (firstRunEdge != DEPTH + 1) begin
         errors++;
         $display("[TB] FAIL clear_timing: first RUN edge %0d expected %0d", firstRunEdge, DEPTH + 1);
      end
      checks++;
      if (weCycles != DEPTH) begin
         errors++;
         $display("[TB] FAIL clear_we_cycles: got %0d expected %0d", weCycles, DEPTH);
      end
      checks++;
      if (shadowRam[8'h7F] !== '0) begin
         errors++;
         $display("[TB] FAIL clear_read_7f: got %h expected 0", shadowRam[8'h7F]);
      end
      for (int a = 0; a < DEPTH; a++) if (shadowRam[a] !== '0) nonZero++;
      checks++;
      if (nonZero != 0) begin
         errors++;
         $display("[TB] FAIL clear_all_zero: got %0d nonzero words expected 0", nonZero);
      end
   endtask

   task automatic test_round_robin();
      logic [NREQ-1:0] expOrder;
      for (int c = 0; c < 8; c++) begin
         req_valid = '1;
         randomizeData();
         #1;
         expOrder = NREQ'(1 << (c % NREQ));
         checks++;
         if (req_ready !== expOrder) begin
            errors++;
            $display("[TB] FAIL rr_order: cycle %0d got %b expected %b", c, req_ready, expOrder);
         end
         clockEdge();
         @(negedge signal_C);
         checks++;
         if ({ram_we, ram_addr, ram_data} !== {mWe, mAddr, mData}) begin
            errors++;
            $display("[TB] FAIL rr_write: got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                     ram_we, ram_addr, ram_data, mWe, mAddr, mData);
         end
      end
      req_valid = '0;
      #1;
      checks++;
      if (grant_count !== expectedCounts()) begin
         errors++;
         $display("[TB] FAIL rr_stats: got %h expected %h", grant_count, expectedCounts());
      end
   endtask

   task automatic test_single();
      randomizeData();
      req_valid = 4'b0100;
      req_addr[2*AW +: AW] = 8'h10;
      req_data[2*DW +: DW] = 32'hDEADBEEF;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL single_ready: got %b expected 0100", req_ready);
      end
      clockEdge();
      req_valid = '0;
      @(negedge signal_C);
      checks++;
      if ({ram_we, ram_addr, ram_data} !== {1'b1, 8'h10, 32'hDEADBEEF}) begin
         errors++;
         $display("[TB] FAIL single_write: got we=%b addr=%h data=%h expected we=1 addr=10 data=deadbeef",
                  ram_we, ram_addr, ram_data);
      end
      clockEdge();
      @(negedge signal_C);
      checks++;
      if ({ram_we, ram_addr, ram_data} !== {1'b0, 8'h10, 32'hDEADBEEF}) begin
         errors++;
         $display("[TB] FAIL idle_hold: got we=%b addr=%h data=%h expected we=0 addr=10 data=deadbeef",
                  ram_we, ram_addr, ram_data);
      end
   endtask

   task automatic test_clr_start();
      int zeroWrites;
      zeroWrites = 0;
      randomizeData();
      req_valid = 4'b0011;
      clr_start = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL clr_ready: got %b expected 0000", req_ready);
      end
      clockEdge();
      clr_start = 1'b0;
      @(negedge signal_C);
      for (int e = 0; e < DEPTH + 20 && init_done !== 1'b1; e++) begin
         #1;
         checks++;
         if (req_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL clr_hold_ready: got %b expected 0000", req_ready);
         end
         clockEdge();
         @(negedge signal_C);
         checks++;
         if ({init_done, ram_we, ram_addr, ram_data} !== {mRun, mWe, mAddr, mData}) begin
            errors++;
            $display("[TB] FAIL clr_write: got done=%b we=%b addr=%h data=%h expected done=%b we=%b addr=%h data=%h",
                     init_done, ram_we, ram_addr, ram_data, mRun, mWe, mAddr, mData);
         end
         if (ram_we === 1'b1 && ram_data === '0) zeroWrites++;
      end
      checks++;
      if (zeroWrites != DEPTH || init_done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL clr_sequence: got %0d zero writes done=%b expected %0d done=1", zeroWrites, init_done, DEPTH);
      end
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL clr_first_grant: got %b expected 0001", req_ready);
      end
      clockEdge();
      req_valid = '0;
      @(negedge signal_C);
      checks++;
      if ({ram_we, ram_addr, ram_data} !== {1'b1, req_addr[0 +: AW], req_data[0 +: DW]}) begin
         errors++;
         $display("[TB] FAIL clr_first_write: got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                  ram_we, ram_addr, ram_data, req_addr[0 +: AW], req_data[0 +: DW]);
      end
   endtask

   task automatic test_reset_mid_clear();
      req_valid = '0;
      clr_start = 1'b1;
      #1;
      clockEdge();
      clr_start = 1'b0;
      @(negedge signal_C);
      for (int e = 0; e < DEPTH && mClr != 100; e++) begin
         clockEdge();
         @(negedge signal_C);
      end
      checks++;
      if ({ram_we, ram_addr} !== {1'b1, 8'd99}) begin
         errors++;
         $display("[TB] FAIL mid_clear_pos: got we=%b addr=%h expected we=1 addr=63", ram_we, ram_addr);
      end
      signal_R = 1'b1;
      #1;
      modelReset();
      checks++;
      if ({ram_we, init_done, req_ready} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_drop: got we=%b done=%b ready=%b expected all zero", ram_we, init_done, req_ready);
      end
      repeat (2) @(posedge signal_C);
      @(negedge signal_C);
      signal_R = 1'b0;
      clockEdge();
      @(negedge signal_C);
      checks++;
      if ({ram_we, ram_addr, ram_data} !== {1'b1, 8'h00, 32'h0}) begin
         errors++;
         $display("[TB] FAIL restart_addr0: got we=%b addr=%h data=%h expected we=1 addr=00 data=0",
                  ram_we, ram_addr, ram_data);
      end
      for (int e = 0; e < DEPTH + 20 && init_done !== 1'b1; e++) begin
         clockEdge();
         @(negedge signal_C);
         checks++;
         if ({init_done, ram_we, ram_addr, ram_data} !== {mRun, mWe, mAddr, mData}) begin
            errors++;
            $display("[TB] FAIL restart_write: got done=%b we=%b addr=%h expected done=%b we=%b addr=%h",
                     init_done, ram_we, ram_addr, mRun, mWe, mAddr);
         end
      end
      checks++;
      if (init_done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL restart_done: got %b expected 1", init_done);
      end
   endtask

   task automatic test_fairness();
      int hsSince;
      int w3Grants;
      hsSince = 0; w3Grants = 0;
      for (int c = 0; c < 300; c++) begin
         req_valid = {1'b1, 3'($urandom)};
         randomizeData();
         #1;
         checks++;
         if (req_ready !== expectedReady()) begin
            errors++;
            $display("[TB] FAIL fair_ready: cycle %0d got %b expected %b", c, req_ready, expectedReady());
         end
         if (|req_ready) hsSince++;
         if (req_ready[3] === 1'b1) begin
            checks++;
            if (hsSince > NREQ) begin
               errors++;
               $display("[TB] FAIL fair_bound: writer 3 waited %0d handshakes, limit %0d", hsSince, NREQ);
            end
            hsSince = 0;
            w3Grants++;
         end
         clockEdge();
         @(negedge signal_C);
         checks++;
         if ({ram_we, ram_addr, ram_data} !== {mWe, mAddr, mData}) begin
            errors++;
            $display("[TB] FAIL fair_write: got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                     ram_we, ram_addr, ram_data, mWe, mAddr, mData);
         end
      end
      req_valid = '0;
      checks++;
      if (w3Grants < 300 / NREQ) begin
         errors++;
         $display("[TB] FAIL fair_count: writer 3 granted %0d times, at least %0d required", w3Grants, 300 / NREQ);
      end
      #1;
      checks++;
      if (grant_count !== expectedCounts()) begin
         errors++;
         $display("[TB] FAIL fair_stats: got %h expected %h", grant_count, expectedCounts());
      end
   endtask

   initial begin
      for (int a = 0; a < DEPTH; a++) shadowRam[a] = 32'hA5A5A5A5;
      $display("[TB] starting ram_write_arbiter bench");
      test_reset();
      test_clear();
      test_round_robin();
      test_single();
      test_clr_start();
      test_reset_mid_clear();
      test_fairness();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
